// File: rtl/pwm_pkg.sv
// Shared widths and constants for the 16-channel PWM peripheral.
package pwm_pkg;

  localparam int unsigned NUM_CH = 16;
  localparam int unsigned PWM_W  = 8;
  localparam logic [PWM_W-1:0] DUTY_FULL = 8'hFF;

  // Duty 0xFF means always high; otherwise high while the step count is below duty.
  function automatic logic pwm_level(input logic [PWM_W-1:0] cnt,
                                     input logic [PWM_W-1:0] duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit PWM step counter; flags the step tick and the 255->0 wrap.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE_DIV = 13
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             tick_c_o,
  output logic [PWM_W-1:0] pwm_cnt_o,
  output logic             wrap_c_o
);

  localparam int unsigned PRE_W = 8;
  localparam logic [PWM_W-1:0] CNT_MAX = '1;

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [PWM_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_c_o  = (pre_cnt_q == PRE_W'(PRESCALE_DIV - 1));
    wrap_c_o  = tick_c_o && (cnt_q == CNT_MAX);
    pre_cnt_d = tick_c_o ? '0 : pre_cnt_q + PRE_W'(1);
    cnt_d     = tick_c_o ? cnt_q + PWM_W'(1) : cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pwm_cnt_o = cnt_q;

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel PWM/static output block sharing one duty cycle, latched once per period.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned PRESCALE_DIV = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        en_reg_out_7_0,
  input  logic [7:0]        en_reg_out_15_8,
  input  logic [7:0]        en_reg_pwm_7_0,
  input  logic [7:0]        en_reg_pwm_15_8,
  input  logic [PWM_W-1:0]  pwm_duty_cycle,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  logic              tick_c, wrap_c;
  logic [PWM_W-1:0]  pwm_cnt;
  logic [PWM_W-1:0]  duty_shadow_q, duty_shadow_d;
  logic [NUM_CH-1:0] out_q, out_d;
  logic              period_start_q, period_start_d;
  logic [NUM_CH-1:0] en_out_c, en_pwm_c;
  logic              pwm_raw_c;

  pwm_timebase #(
    .PRESCALE_DIV(PRESCALE_DIV)
  ) u_timebase (
    .clk_i    (clk),
    .rst_i    (rst),
    .tick_c_o (tick_c),
    .pwm_cnt_o(pwm_cnt),
    .wrap_c_o (wrap_c)
  );

  // Duty is only sampled at the wrap so a period never sees a mid-flight change.
  always_comb begin
    en_out_c       = {en_reg_out_15_8, en_reg_out_7_0};
    en_pwm_c       = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    pwm_raw_c      = pwm_level(pwm_cnt, duty_shadow_q);
    duty_shadow_d  = duty_shadow_q;
    if (tick_c && wrap_c) begin
      duty_shadow_d = pwm_duty_cycle;
    end
    out_d          = en_out_c & (~en_pwm_c | {NUM_CH{pwm_raw_c}});
    period_start_d = wrap_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow_q  <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      duty_shadow_q  <= duty_shadow_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench: DIV=1 and DIV=13 instances against an arithmetic reference model.
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] en_out, en_pwm;
  logic [7:0]  duty;
  logic [15:0] out_a, out_b;
  logic        ps_a, ps_b;

  int errors = 0;
  int checks = 0;

  int unsigned div_m [2] = '{1, 13};
  int unsigned n_m   [2];
  logic [7:0]  duty_m[2];
  logic [15:0] out_m [2];
  logic        ps_m  [2];

  always #5 clk = ~clk;

  pwm_peripheral #(.PRESCALE_DIV(1)) u_div1 (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle(duty), .out(out_a), .period_start(ps_a)
  );

  pwm_peripheral #(.PRESCALE_DIV(13)) u_div13 (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(en_out[7:0]), .en_reg_out_15_8(en_out[15:8]),
    .en_reg_pwm_7_0(en_pwm[7:0]), .en_reg_pwm_15_8(en_pwm[15:8]),
    .pwm_duty_cycle(duty), .out(out_b), .period_start(ps_b)
  );

  // Model: n counts clocks since reset release; step = n/DIV mod 256, period = 256*DIV.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        n_m[k] = 0; duty_m[k] = 8'h00; out_m[k] = 16'h0000; ps_m[k] = 1'b0;
      end else begin
        int unsigned pos;
        logic lvl;
        pos = (n_m[k] / div_m[k]) % 256;
        lvl = (duty_m[k] == 8'hFF) || (pos < int'(duty_m[k]));
        for (int i = 0; i < 16; i++) out_m[k][i] = en_out[i] && (!en_pwm[i] || lvl);
        ps_m[k] = ((n_m[k] + 1) % (256 * div_m[k])) == 0;
        if (ps_m[k]) duty_m[k] = duty;
        n_m[k] = (n_m[k] + 1) % (256 * div_m[k]);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("out_div1", 32'(out_a), 32'(out_m[0]));
    check("ps_div1", 32'(ps_a), 32'(ps_m[0]));
    check("out_div13", 32'(out_b), 32'(out_m[1]));
    check("ps_div13", 32'(ps_b), 32'(ps_m[1]));
  endtask

  // Step until instance k pulses period_start; counts clocks and out[0] highs on the way.
  task automatic wait_ps(input int k, input int limit, output int taken, output int hi);
    bit got;
    got = 1'b0; taken = 0; hi = 0;
    while (!got && taken < limit) begin
      step();
      taken++;
      got = (k == 0) ? ps_a : ps_b;
      hi += (k == 0) ? int'(out_a[0]) : int'(out_b[0]);
    end
    check("ps_timeout", 32'(got), 32'd1);
  endtask

  task automatic count_high(input int k, input int len, output int hi, output logic [15:0] rest);
    hi = 0; rest = '0;
    for (int i = 0; i < len; i++) begin
      step();
      hi   += (k == 0) ? int'(out_a[0]) : int'(out_b[0]);
      rest |= (k == 0) ? {out_a[15:1], 1'b0} : {out_b[15:1], 1'b0};
    end
  endtask

  initial begin
    int t, h, h2;
    logic [15:0] rest;

    rst = 1'b1; en_out = '0; en_pwm = '0; duty = 8'h00;
    repeat (3) step();
    check("reset_out", 32'(out_a), 32'h0);
    check("reset_ps", 32'(ps_a), 32'h0);

    // Static outputs, period_start spacing at DIV=1
    rst = 1'b0; en_out = 16'hFFFF; en_pwm = 16'h0000;
    step();
    check("static_out_latency", 32'(out_a), 32'hFFFF);
    wait_ps(0, 300, t, h);
    check("first_period_start", 32'(t), 32'd255);
    wait_ps(0, 300, t, h);
    check("period_len_div1", 32'(t), 32'd256);

    // Half duty on channel 0 only
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
    wait_ps(0, 300, t, h);
    count_high(0, 256, h, rest);
    check("duty80_high", 32'(h), 32'd128);
    check("duty80_others_low", 32'(rest), 32'h0);

    // Duty extremes
    duty = 8'h00;
    wait_ps(0, 300, t, h);
    count_high(0, 256, h, rest);
    check("duty00_high", 32'(h), 32'd0);
    duty = 8'hFF;
    wait_ps(0, 300, t, h);
    count_high(0, 256, h, rest);
    check("dutyFF_high", 32'(h), 32'd256);

    // Mid-period duty change waits for the next period
    duty = 8'h40;
    wait_ps(0, 300, t, h);
    count_high(0, 16, h, rest);
    duty = 8'hC0;
    count_high(0, 240, h2, rest);
    check("duty_change_cur", 32'(h + h2), 32'd64);
    count_high(0, 256, h, rest);
    check("duty_change_next", 32'(h), 32'd192);

    // DIV=13 instance: one-step pulse width and period
    duty = 8'h01;
    wait_ps(1, 3400, t, h);
    wait_ps(1, 3400, t, h);
    check("period_len_div13", 32'(t), 32'd3328);
    check("pulse_div13", 32'(h), 32'd13);

    // Reset in mid-period at step 0x7F
    duty = 8'h80;
    wait_ps(0, 300, t, h);
    repeat (127) step();
    rst = 1'b1;
    step();
    check("midrst_out_div1", 32'(out_a), 32'h0);
    check("midrst_out_div13", 32'(out_b), 32'h0);
    check("midrst_ps", 32'(ps_a), 32'h0);
    rst = 1'b0;
    wait_ps(0, 300, t, h);
    check("midrst_first_wrap", 32'(t), 32'd256);
    check("midrst_low_until_wrap", 32'(h), 32'd0);
    count_high(0, 256, h, rest);
    check("midrst_duty_loaded", 32'(h), 32'd128);

    // Random register traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) en_out = 16'($urandom);
      if ($urandom_range(0, 7) == 0) en_pwm = 16'($urandom);
      if ($urandom_range(0, 15) == 0) duty = 8'($urandom);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 SHALL have parameter PRESCALE_DIV, default 13, meaning system clocks per PWM counter step (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port en_reg_out_7_0  input  8  output enable, channels 7..0.
REQ-005 SHALL have port en_reg_out_15_8  input  8  output enable, channels 15..8.
REQ-006 SHALL have port en_reg_pwm_7_0  input  8  PWM mode select, channels 7..0.
REQ-007 SHALL have port en_reg_pwm_15_8  input  8  PWM mode select, channels 15..8.
REQ-008 SHALL have port pwm_duty_cycle  input  8  duty cycle shared by all PWM channels, 0x00..0xFF.
REQ-009 SHALL have port out  output  16  channel outputs, bit i = channel i.
REQ-010 SHALL have port period_start  output  1  one-cycle pulse marking the first cycle of each PWM period.

Function
REQ-011 SHALL treat all register inputs as already synchronous to clk; no input synchronisers.
REQ-012 SHALL run prescaler counter pre_cnt 0..PRESCALE_DIV-1, wrapping to 0; tick = (pre_cnt == PRESCALE_DIV-1); PRESCALE_DIV=1 gives tick every cycle.
REQ-013 SHALL advance 8-bit pwm_cnt by 1 on each tick, wrapping 255 -> 0 (period = 256 x PRESCALE_DIV clocks).
REQ-014 SHALL load duty_shadow <= pwm_duty_cycle on the tick where pwm_cnt wraps 255 -> 0; pwm_duty_cycle changes mid-period SHALL NOT affect the current period.
REQ-015 SHALL compute pwm_raw = 1 when duty_shadow == 0xFF, else (pwm_cnt < duty_shadow); duty 0x00 gives constant low.
REQ-016 SHALL register out[i] <= en_out[i] & (en_pwm[i] ? pwm_raw : 1), where en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm likewise.
REQ-017 SHALL apply enable/mode changes with exactly 1 clock latency, without waiting for a period boundary.
REQ-018 SHALL assert period_start for exactly one clock, in the cycle pwm_cnt first holds 0 after a wrap.
REQ-019 SHALL keep pwm_raw high for exactly duty_shadow x PRESCALE_DIV clocks per period when duty_shadow < 0xFF.
REQ-020 SHALL treat en_out=0 as dominant: channel low regardless of en_pwm or duty.

Reset
REQ-021 SHALL, while rst=1 at a clk edge, set pre_cnt=0, pwm_cnt=0, duty_shadow=0x00, out=16'h0000, period_start=0.
REQ-022 SHALL begin counting on the first edge with rst=0; first duty_shadow load occurs at the first 255 -> 0 wrap.
REQ-023 SHALL, on rst asserted mid-period, abandon the period and restore REQ-021 values on that edge.

Structure
REQ-024 SHALL take NUM_CH=16, PWM_W=8, DUTY_FULL=8'hFF from shared package pwm_pkg.
REQ-025 SHALL place prescaler + pwm_cnt + wrap detection in one sub-module pwm_timebase (outputs tick, pwm_cnt, wrap); output logic stays in pwm_peripheral.

Verification
REQ-026 SHALL check: PRESCALE_DIV=1, en_out=FFFF, en_pwm=0000 -> out=FFFF one clock after inputs applied, period_start every 256 clocks.
REQ-027 SHALL check: PRESCALE_DIV=1, en_out=0001, en_pwm=0001, duty=0x80 -> out[0] high 128 of 256 clocks per period, out[15:1]=0.
REQ-028 SHALL check: duty=0x00 -> out[0] constant 0; duty=0xFF -> out[0] constant 1 across full periods.
REQ-029 SHALL check: duty changed 0x40 -> 0xC0 at pwm_cnt=0x10 -> current period high 64 steps, next period high 192 steps.
REQ-030 SHALL check: PRESCALE_DIV=13, duty=0x01 -> high pulse 13 clocks, period 3328 clocks between period_start pulses.
REQ-031 SHALL check: rst asserted at pwm_cnt=0x7F -> next edge out=0000, pwm_cnt=0, duty_shadow=0; outputs low until first wrap loads duty.
